dcache_ctrl: RTL and testbench

Data-cache controller sitting directly upstream of the 32-line `dcache_ram` array. It accepts single 16-bit load/store requests from the CPU memory stage and performs tag lookup through the array's 1-cycle synchronous read port. On a miss it writes back a dirty victim and refills the line over a single-word memory bus. Direct-mapped, write-back, 4 words per line.

---
 rtl/dcache_ctrl_if.sv | 41 ++++
 rtl/dcache_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Signal bundle around dcache_ctrl: CPU request port, dcache_ram array port and memory bus.
// master = cache controller side, slave = CPU / array / memory side.
interface dcache_ctrl_if;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned LINE_W = 82;

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_data;
  logic [SEL_W-1:0]  i_sel;
  logic [WORD_W-1:0] o_data;
  logic              o_ack;

  logic [IDX_W-1:0]  o_ram_addr;
  logic [LINE_W-1:0] o_ram_data;
  logic [LINE_W-1:0] i_ram_data;
  logic              o_ram_we;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_data;
  logic [WORD_W-1:0] i_mem_data;
  logic              i_mem_ack;

  modport master (
    input  i_req, i_we, i_addr, i_data, i_sel, i_ram_data, i_mem_data, i_mem_ack,
    output o_data, o_ack, o_ram_addr, o_ram_data, o_ram_we,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_data
  );

  modport slave (
    output i_req, i_we, i_addr, i_data, i_sel, i_ram_data, i_mem_data, i_mem_ack,
    input  o_data, o_ack, o_ram_addr, o_ram_data, o_ram_we,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data-cache controller: 32 lines x 4 words, dirty writeback and refill.
// DCACHE_WRITE_ALLOCATE_EN: when defined store misses allocate; otherwise they write through.
module dcache_ctrl #(
  parameter int unsigned TAG_W      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dcache_ctrl_if.master bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = WORD_W / 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] words_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    words_t           words;
    logic             dirty;
    logic             valid;
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WB, ST_FILL, ST_LINEWR, ST_WT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  words_t            buf_q, buf_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;

  line_t             rd_line, wr_line;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic              hit_c;
  logic              mem_done_c;

`ifdef DCACHE_WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
  // Write-through misses only carry full words to memory.
  wt_full_word: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == ST_LOOKUP && we_q && !hit_c) |-> (sel_q == '1));
`endif

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_w,
                                                    input logic [WORD_W-1:0] new_w,
                                                    input logic [SEL_W-1:0]  sel);
    merge_bytes = old_w;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
    end
  endfunction

  assign rd_line    = line_t'(bus.i_ram_data);
  assign tag_q      = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q      = addr_q[OFF_W +: IDX_W];
  assign off_q      = addr_q[OFF_W-1:0];
  assign hit_c      = rd_line.valid && (rd_line.tag == tag_q);
  // A memory ack only counts while our request is up.
  assign mem_done_c = mem_req_q && bus.i_mem_ack;

  assign bus.o_mem_req  = mem_req_q;
  assign bus.o_mem_we   = mem_we_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_ram_data = wr_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      buf_q      <= '0;
      vtag_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      vtag_q     <= vtag_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    sel_d          = sel_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    vtag_d         = vtag_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    wr_line        = '0;
    bus.o_ack      = 1'b0;
    bus.o_data     = '0;
    bus.o_ram_we   = 1'b0;
    bus.o_ram_addr = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        bus.o_ram_addr = bus.i_addr[OFF_W +: IDX_W];
        if (bus.i_req) begin
          addr_d  = bus.i_addr;
          wdata_d = bus.i_data;
          sel_d   = bus.i_sel;
          we_d    = bus.i_we;
          cnt_d   = '0;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (hit_c) begin
          bus.o_ack = 1'b1;
          state_d   = ST_IDLE;
          if (we_q) begin
            wr_line              = rd_line;
            wr_line.words[off_q] = merge_bytes(rd_line.words[off_q], wdata_q, sel_q);
            wr_line.dirty        = 1'b1;
            bus.o_ram_we         = 1'b1;
          end else begin
            bus.o_data = rd_line.words[off_q];
          end
        end else begin
          // Victim captured now; the array port is about to be reused for the refill write.
          buf_d  = rd_line.words;
          vtag_d = rd_line.tag;
          if (we_q && !ALLOC)                      state_d = ST_WT;
          else if (rd_line.valid && rd_line.dirty) state_d = ST_WB;
          else                                     state_d = ST_FILL;
        end
      end

      ST_WB: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = {vtag_q, idx_q, cnt_q};
          mem_data_d = buf_q[cnt_q];
        end else if (mem_done_c) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_q, idx_q, cnt_q};
        end else if (mem_done_c) begin
          mem_req_d    = 1'b0;
          buf_d[cnt_q] = bus.i_mem_data;
          cnt_d        = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) state_d = ST_LINEWR;
        end
      end

      ST_LINEWR: begin
        wr_line.tag   = tag_q;
        wr_line.words = buf_q;
        wr_line.dirty = we_q;
        wr_line.valid = 1'b1;
        if (we_q) wr_line.words[off_q] = merge_bytes(buf_q[off_q], wdata_q, sel_q);
        else      bus.o_data           = buf_q[off_q];
        bus.o_ram_we = 1'b1;
        bus.o_ack    = 1'b1;
        state_d      = ST_IDLE;
      end

      ST_WT: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = wdata_q;
        end else if (mem_done_c) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus.o_ack = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: array and memory models, directed scenarios, then random loads/stores
// checked against a line-level cache model.
module tb_dcache_ctrl;
`ifdef DCACHE_WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic [15:0] data;
  } op_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  dcache_ctrl_if bus();
  dcache_ctrl dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // Array model: 1-cycle synchronous read, valid bits cleared by reset.
  logic [81:0] ram [32];
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) ram[i][0] <= 1'b0;
      bus.i_ram_data <= '0;
    end else begin
      if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_data;
      bus.i_ram_data <= ram[bus.o_ram_addr];
    end
  end

  // Backing memory shared by the responder; the reference keeps its own copy.
  logic [15:0] mem     [logic [22:0]];
  logic [15:0] ref_mem [logic [22:0]];
  op_t obs_q[$];
  op_t exp_q[$];

  function automatic logic [15:0] mem_init(input logic [22:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  initial begin
    int          wait_n;
    logic [22:0] a;
    bus.i_mem_ack  = 1'b0;
    bus.i_mem_data = '0;
    wait_n = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        bus.i_mem_ack = 1'b0;
        wait_n        = 0;
      end else if (bus.i_mem_ack) begin
        bus.i_mem_ack = 1'b0;
      end else if (bus.o_mem_req) begin
        if (wait_n > 0) wait_n--;
        else begin
          a = bus.o_mem_addr;
          if (bus.o_mem_we) begin
            mem[a] = bus.o_mem_data;
            obs_q.push_back('{1'b1, a, bus.o_mem_data});
          end else begin
            bus.i_mem_data = mem.exists(a) ? mem[a] : mem_init(a);
            obs_q.push_back('{1'b0, a, bus.i_mem_data});
          end
          bus.i_mem_ack = 1'b1;
          wait_n        = $urandom_range(0, 2);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray ack with garbage data while nothing is outstanding
        bus.i_mem_data = 16'hDEAD;
        bus.i_mem_ack  = 1'b1;
      end
    end
  end

  // Reference cache state.
  bit          mv    [32];
  bit          mdirty[32];
  logic [15:0] mt    [32];
  logic [15:0] md    [32][4];

  function automatic logic [15:0] ref_read(input logic [22:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [15:0] apply_sel(input logic [15:0] old_w, input logic [15:0] new_w,
                                            input logic [1:0] sel);
    logic [15:0] mask;
    mask = {{8{sel[1]}}, {8{sel[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic bit pred_hit(input logic [22:0] a);
    return mv[a[6:2]] && (mt[a[6:2]] == a[22:7]);
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic we, input logic [22:0] addr, input logic [15:0] data,
                       input logic [1:0] sel, output logic [15:0] rdata, output int cyc);
    logic [4:0]  idx;
    logic [15:0] tag;
    logic [1:0]  off;
    logic [22:0] a;
    logic [15:0] exp_data, d;
    logic [81:0] exp_line;
    bit          hit, wt;
    int          ramwe;
    idx = addr[6:2]; tag = addr[22:7]; off = addr[1:0];
    hit = pred_hit(addr); wt = 1'b0; exp_data = '0;
    exp_q.delete();
    obs_q.delete();

    if (hit) begin
      if (we) begin
        md[idx][off] = apply_sel(md[idx][off], data, sel);
        mdirty[idx]  = 1'b1;
      end else exp_data = md[idx][off];
    end else if (we && !ALLOC) begin
      wt = 1'b1;
      exp_q.push_back('{1'b1, addr, data});
      ref_mem[addr] = data;
    end else begin
      if (mv[idx] && mdirty[idx]) begin
        for (int n = 0; n < 4; n++) begin
          a = {mt[idx], idx, 2'(n)};
          exp_q.push_back('{1'b1, a, md[idx][n]});
          ref_mem[a] = md[idx][n];
        end
      end
      for (int n = 0; n < 4; n++) begin
        a = {tag, idx, 2'(n)};
        d = ref_read(a);
        exp_q.push_back('{1'b0, a, d});
        md[idx][n] = d;
      end
      mt[idx] = tag; mv[idx] = 1'b1; mdirty[idx] = we;
      exp_data = md[idx][off];
      if (we) md[idx][off] = apply_sel(md[idx][off], data, sel);
    end

    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_data = data; bus.i_sel = sel;
    cyc = 0; ramwe = 0;
    do begin
      @(negedge i_clk); #1;
      cyc++;
      if (bus.o_ram_we) ramwe++;
      if (!bus.o_ack) begin
        bus.i_addr = 23'($urandom);
        bus.i_data = 16'($urandom);
      end
    end while (!bus.o_ack && cyc < 400);
    check("ack_seen", 96'(bus.o_ack), 96'(1));
    rdata = bus.o_data;
    bus.i_req = 1'b0;
    if (hit)          check("hit_latency", 96'(cyc), 96'(1));
    if (!we)          check("load_data", 96'(rdata), 96'(exp_data));
    if (wt || (hit && !we)) check("no_ram_we", 96'(ramwe), 96'(0));

    @(negedge i_clk); #1;
    check("mem_op_count", 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("mem_op", 96'(obs_q[i]), 96'(exp_q[i]));
    if (mv[idx]) begin
      exp_line = {mt[idx], md[idx][3], md[idx][2], md[idx][1], md[idx][0], mdirty[idx], 1'b1};
      check("array_line", 96'(ram[idx]), 96'(exp_line));
    end else check("array_invalid", 96'(ram[idx][0]), 96'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},      96'(bus.o_ack),      96'(0));
    check({tag, "_ram_we"},   96'(bus.o_ram_we),   96'(0));
    check({tag, "_mem_req"},  96'(bus.o_mem_req),  96'(0));
    check({tag, "_mem_we"},   96'(bus.o_mem_we),   96'(0));
    check({tag, "_data"},     96'(bus.o_data),     96'(0));
    check({tag, "_mem_addr"}, 96'(bus.o_mem_addr), 96'(0));
    check({tag, "_mem_data"}, 96'(bus.o_mem_data), 96'(0));
  endtask

  initial begin
    logic [15:0] rd;
    logic [22:0] a;
    logic [1:0]  sel;
    logic        we;
    int          cyc, t;

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_data = '0; bus.i_sel = '0;
    for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; mdirty[i] = 1'b0; mt[i] = '0; end
    mem[23'h5]     = 16'h1234;
    ref_mem[23'h5] = 16'h1234;

    repeat (3) @(negedge i_clk);
    #1;
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk); #1;

    // clean miss, then hit on the same word
    do_op(1'b0, 23'h000004, 16'h0, 2'b00, rd, cyc);
    check("miss_word0", 96'(rd), 96'(mem_init(23'h4)));
    check("miss_valid_clean", 96'(ram[1][1:0]), 96'(2'b01));
    do_op(1'b0, 23'h000004, 16'h0, 2'b00, rd, cyc);
    check("rehit_latency", 96'(cyc), 96'(1));

    // upper-byte store over 0x1234
    do_op(1'b1, 23'h000005, 16'hBEEF, 2'b10, rd, cyc);
    check("store_hit_latency", 96'(cyc), 96'(1));
    check("store_merge", 96'(ram[1][33:18]), 96'(16'hBE34));
    check("store_dirty", 96'(ram[1][1]), 96'(1));

    // conflicting load forces writeback of the dirty line
    do_op(1'b0, 23'h000085, 16'h0, 2'b00, rd, cyc);
    check("wb_word1", 96'(obs_q[1]), 96'({1'b1, 23'h000005, 16'hBE34}));
    check("fill_first_addr", 96'(obs_q[4].addr), 96'(23'h000084));

    // reset in the middle of a refill
    obs_q.delete();
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 23'h000104; bus.i_sel = 2'b00;
    t = 0;
    while (!(bus.o_mem_req && bus.o_mem_addr == 23'h000106) && t < 400) begin
      @(negedge i_clk); #1;
      t++;
    end
    check("reach_fill_word2", 96'(t < 400), 96'(1));
    #2 i_rst_n = 1'b0;
    #1;
    check_outputs_zero("midfill_reset");
    bus.i_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    @(negedge i_clk); #1;
    do_op(1'b0, 23'h000104, 16'h0, 2'b00, rd, cyc);
    check("post_reset_miss_ops", 96'(obs_q.size()), 96'(4));

`ifndef DCACHE_WRITE_ALLOCATE_EN
    do_op(1'b1, 23'h000300, 16'hCAFE, 2'b11, rd, cyc);
    check("wt_single_write", 96'(obs_q.size()), 96'(1));
`endif

    for (int k = 0; k < 200; k++) begin
      a   = {16'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'($urandom)};
      we  = ($urandom_range(0, 9) < 4);
      sel = (we && !ALLOC && !pred_hit(a)) ? 2'b11 : 2'($urandom);
      do_op(we, a, 16'($urandom), sel, rd, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
